// File: rtl/adc_frame_capture.sv
// ADC frame capture: handshakes with the readout FSM, writes one frame of
// row-bursted ADC samples into a linear buffer, then drains and acknowledges.
// Optional feature: define ADC_FRAME_CAPTURE_TESTPAT_EN to replace the write
// data with the low bits of the write address (timing and flags unchanged).
module adc_frame_capture #(
    parameter int DATA_W            = 12,
    parameter int C_NUM_ROWS        = 160,
    parameter int C_SAMPLES_PER_ROW = 138,
    parameter int ADDR_W            = 15,
    parameter int C_DRAIN           = 32,
    parameter int C_ACK_LEN         = 3
) (
    input  logic              ADC_CLK,
    input  logic              RESET,
    input  logic              ARM,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_DATA_VALID,
    input  logic              FSMIND0,
    output logic              FSMIND0ACK,
    output logic              FSMIND1,
    input  logic              FSMIND1ACK,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic [7:0]        ROW_IDX,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output logic              OVERFLOW,
    output logic              SHORT_ROW
);

    localparam int SAMPLE_W = $clog2(C_SAMPLES_PER_ROW + 1);
    localparam int DRAIN_W  = $clog2(C_DRAIN + 1);
    localparam int ACK_W    = $clog2(C_ACK_LEN + 1);

    localparam logic [SAMPLE_W-1:0] SPR        = SAMPLE_W'(C_SAMPLES_PER_ROW);
    localparam logic [7:0]          ROWS       = 8'(C_NUM_ROWS);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(C_DRAIN - 1);
    localparam logic [ACK_W-1:0]    ACK_LAST   = ACK_W'(C_ACK_LEN - 1);
    localparam logic [ADDR_W-1:0]   ROW_STRIDE = ADDR_W'(C_SAMPLES_PER_ROW);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        DRAIN,
        ACK,
        DONE
    } state_t;

    state_t                state;
    logic [7:0]            row;
    logic [SAMPLE_W-1:0]   sample;
    logic [ADDR_W-1:0]     row_base;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic [ACK_W-1:0]      ack_cnt;
    logic                  valid_d;

    logic                  capturing;
    logic                  in_range;
    logic                  accept;
    logic                  drop;
    logic                  row_close;
    logic [ADDR_W-1:0]     addr_next;
    logic [DATA_W-1:0]     data_next;

    // Sample acceptance, row-close detection and next write address/data
    always_comb begin
        capturing = (state == CAPTURE) || (state == DRAIN);
        in_range  = (sample < SPR) && (row < ROWS);
        accept    = capturing && ADC_DATA_VALID && in_range;
        drop      = capturing && ADC_DATA_VALID && !in_range;
        row_close = capturing && valid_d && !ADC_DATA_VALID;
        addr_next = row_base + ADDR_W'(sample);
`ifdef ADC_FRAME_CAPTURE_TESTPAT_EN
        data_next = addr_next[DATA_W-1:0];
`else
        data_next = ADC_DATA;
`endif
    end

`ifdef ADC_FRAME_CAPTURE_TESTPAT_EN
    logic unused_adc_data;
    assign unused_adc_data = ^ADC_DATA;
`endif

    assign ROW_IDX = row;

    // Capture FSM with registered handshake outputs, write port and sticky flags
    always_ff @(posedge ADC_CLK) begin
        if (RESET) begin
            state      <= IDLE;
            row        <= '0;
            sample     <= '0;
            row_base   <= '0;
            drain_cnt  <= '0;
            ack_cnt    <= '0;
            valid_d    <= 1'b0;
            FSMIND0ACK <= 1'b0;
            FSMIND1    <= 1'b0;
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= '0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
            OVERFLOW   <= 1'b0;
            SHORT_ROW  <= 1'b0;
        end else begin
            WR_EN      <= 1'b0;
            FRAME_DONE <= 1'b0;
            valid_d    <= capturing && ADC_DATA_VALID;

            if (accept) begin
                WR_EN   <= 1'b1;
                WR_ADDR <= addr_next;
                WR_DATA <= data_next;
                sample  <= sample + SAMPLE_W'(1);
            end

            if (drop) begin
                OVERFLOW <= 1'b1;
            end

            if (row_close) begin
                sample <= '0;
                if (row < ROWS) begin
                    row      <= row + 8'd1;
                    row_base <= row_base + ROW_STRIDE;
                    if (sample < SPR) begin
                        SHORT_ROW <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (ARM) begin
                        state     <= REQ;
                        FSMIND1   <= 1'b1;
                        BUSY      <= 1'b1;
                        row       <= '0;
                        sample    <= '0;
                        row_base  <= '0;
                        OVERFLOW  <= 1'b0;
                        SHORT_ROW <= 1'b0;
                    end
                end
                REQ: begin
                    if (FSMIND1ACK) begin
                        FSMIND1 <= 1'b0;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (FSMIND0) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (ADC_DATA_VALID) begin
                        drain_cnt <= '0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state      <= ACK;
                        FSMIND0ACK <= 1'b1;
                        ack_cnt    <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ACK: begin
                    if (ack_cnt == ACK_LAST) begin
                        FSMIND0ACK <= 1'b0;
                        FRAME_DONE <= 1'b1;
                        state      <= DONE;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                DONE: begin
                    if (ARM) begin
                        state     <= REQ;
                        FSMIND1   <= 1'b1;
                        row       <= '0;
                        sample    <= '0;
                        row_base  <= '0;
                        OVERFLOW  <= 1'b0;
                        SHORT_ROW <= 1'b0;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture: scoreboard of expected writes,
// handshake timing, row/overflow/short-row flags, reset abort and re-arm.
module tb_adc_frame_capture;

    localparam int DATA_W = 12;
    localparam int ROWS   = 160;
    localparam int SPR    = 138;
    localparam int ADDR_W = 15;

    logic              adc_clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_data_valid = 1'b0;
    logic              fsmind0 = 1'b0;
    logic              fsmind0ack;
    logic              fsmind1;
    logic              fsmind1ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        row_idx;
    logic              frame_done;
    logic              busy;
    logic              overflow;
    logic              short_row;

    int tests_run = 0;
    int tests_failed = 0;
    int write_count = 0;
    int done_count = 0;
    int ack_cycles = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    adc_frame_capture dut (
        .ADC_CLK        (adc_clk),
        .RESET          (reset),
        .ARM            (arm),
        .ADC_DATA       (adc_data),
        .ADC_DATA_VALID (adc_data_valid),
        .FSMIND0        (fsmind0),
        .FSMIND0ACK     (fsmind0ack),
        .FSMIND1        (fsmind1),
        .FSMIND1ACK     (fsmind1ack),
        .WR_EN          (wr_en),
        .WR_ADDR        (wr_addr),
        .WR_DATA        (wr_data),
        .ROW_IDX        (row_idx),
        .FRAME_DONE     (frame_done),
        .BUSY           (busy),
        .OVERFLOW       (overflow),
        .SHORT_ROW      (short_row)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Monitor: pop the scoreboard on every write, count done pulses and ack cycles
    always @(negedge adc_clk) begin
        if (wr_en === 1'b1) begin
            write_count++;
            last_addr = wr_addr;
            if (exp_addr_q.size() == 0) begin
                check_output("unexpected_write", exp_addr_q.size(), 1);
            end else begin
                check_output("wr_addr", wr_addr, exp_addr_q.pop_front());
                check_output("wr_data", wr_data, exp_data_q.pop_front());
            end
        end
        if (frame_done === 1'b1) done_count++;
        if (fsmind0ack === 1'b1) ack_cycles++;
    end

    // Drive one valid burst for a row; optionally raise FSMIND0 at sample index fsmind0_at
    task automatic apply_stimulus(input int row, input int len, input int fsmind0_at);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < len; i++) begin
            @(negedge adc_clk);
            adc_data_valid = 1'b1;
            adc_data = DATA_W'($urandom);
            if (i == fsmind0_at) fsmind0 = 1'b1;
            if (i < SPR && row < ROWS) begin
                a = ADDR_W'(row * SPR + i);
                exp_addr_q.push_back(a);
`ifdef ADC_FRAME_CAPTURE_TESTPAT_EN
                exp_data_q.push_back(a[DATA_W-1:0]);
`else
                exp_data_q.push_back(adc_data);
`endif
            end
        end
        @(negedge adc_clk);
        adc_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge adc_clk);
    endtask

    // ARM pulse, FSMIND1ACK six cycles later; noise drives VALID/FSMIND0 during REQ
    task automatic start_frame(input bit noise);
        @(negedge adc_clk);
        arm = 1'b1;
        write_count = 0;
        done_count = 0;
        ack_cycles = 0;
        @(negedge adc_clk);
        arm = 1'b0;
        check_output("req_fsmind1", fsmind1, 1);
        check_output("req_busy", busy, 1);
        if (noise) begin
            adc_data_valid = 1'b1;
            fsmind0 = 1'b1;
        end
        idle(4);
        check_output("req_hold_fsmind1", fsmind1, 1);
        @(negedge adc_clk);
        fsmind1ack = 1'b1;
        adc_data_valid = 1'b0;
        fsmind0 = 1'b0;
        @(negedge adc_clk);
        fsmind1ack = 1'b0;
        check_output("cap_fsmind1", fsmind1, 0);
        check_output("cap_row_idx", row_idx, 0);
        check_output("cap_overflow", overflow, 0);
        check_output("cap_short_row", short_row, 0);
    endtask

    // Raise FSMIND0, wait (bounded) for FRAME_DONE, check ack length and pulse width
    task automatic finish_frame(input bit exp_busy);
        bit got;
        got = 1'b0;
        @(negedge adc_clk);
        fsmind0 = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge adc_clk);
            if (frame_done === 1'b1) got = 1'b1;
        end
        fsmind0 = 1'b0;
        check_output("frame_done_seen", got, 1);
        @(negedge adc_clk);
        check_output("frame_done_width", frame_done, 0);
        check_output("ack_cycles", ack_cycles, 3);
        check_output("done_count", done_count, 1);
        check_output("busy_after_done", busy, exp_busy);
    endtask

    initial begin
        int lat;
        logic [ADDR_W-1:0] a;

        // Reset state
        idle(3);
        check_output("rst_fsmind0ack", fsmind0ack, 0);
        check_output("rst_fsmind1", fsmind1, 0);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_wr_addr", wr_addr, 0);
        check_output("rst_wr_data", wr_data, 0);
        check_output("rst_row_idx", row_idx, 0);
        check_output("rst_frame_done", frame_done, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_short_row", short_row, 0);
        reset = 1'b0;
        idle(2);

        // Nominal full frame
        start_frame(1'b0);
        for (int r = 0; r < ROWS; r++) begin
            apply_stimulus(r, SPR, -1);
            idle(2);
        end
        check_output("nom_row_idx", row_idx, ROWS);
        finish_frame(1'b0);
        check_output("nom_write_count", write_count, ROWS * SPR);
        check_output("nom_last_addr", last_addr, ROWS * SPR - 1);
        check_output("nom_overflow", overflow, 0);
        check_output("nom_short_row", short_row, 0);

        // Short row, overflow row, FSMIND0 during the last burst; noise during REQ
        start_frame(1'b1);
        apply_stimulus(0, 100, -1);
        idle(2);
        check_output("short_row_set", short_row, 1);
        check_output("short_row_idx", row_idx, 1);
        for (int r = 1; r < 5; r++) begin
            apply_stimulus(r, SPR, -1);
            idle(2);
        end
        check_output("pre_ovf_overflow", overflow, 0);
        apply_stimulus(5, 140, -1);
        idle(2);
        check_output("ovf_set", overflow, 1);
        check_output("ovf_row_idx", row_idx, 6);
        apply_stimulus(6, SPR, -1);
        idle(2);
        apply_stimulus(7, SPR, SPR - 24);
        lat = 0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge adc_clk);
            if (fsmind0ack === 1'b1) lat = c;
        end
        check_output("drain_ack_latency", lat, 32);
        finish_frame(1'b0);
        check_output("b_write_count", write_count, 100 + 4 * SPR + 3 * SPR);
        check_output("b_sticky_overflow", overflow, 1);

        // Reset during row 80, then restart at address 0
        start_frame(1'b0);
        for (int r = 0; r < 80; r++) begin
            apply_stimulus(r, SPR, -1);
            idle(2);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge adc_clk);
            adc_data_valid = 1'b1;
            adc_data = DATA_W'($urandom);
            a = ADDR_W'(80 * SPR + i);
            exp_addr_q.push_back(a);
`ifdef ADC_FRAME_CAPTURE_TESTPAT_EN
            exp_data_q.push_back(a[DATA_W-1:0]);
`else
            exp_data_q.push_back(adc_data);
`endif
        end
        @(negedge adc_clk);
        reset = 1'b1;
        adc_data = DATA_W'($urandom);
        @(negedge adc_clk);
        check_output("abort_wr_en", wr_en, 0);
        check_output("abort_fsmind1", fsmind1, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_row_idx", row_idx, 0);
        reset = 1'b0;
        adc_data_valid = 1'b0;
        idle(2);
        check_output("abort_pending", exp_addr_q.size(), 0);

        start_frame(1'b0);
        apply_stimulus(0, SPR, -1);
        idle(2);
        arm = 1'b1;
        finish_frame(1'b1);
        check_output("rearm_fsmind1", fsmind1, 1);
        arm = 1'b0;
        @(negedge adc_clk);
        fsmind1ack = 1'b1;
        @(negedge adc_clk);
        fsmind1ack = 1'b0;
        check_output("rearm_row_idx", row_idx, 0);
        done_count = 0;
        ack_cycles = 0;
        apply_stimulus(0, 10, -1);
        idle(2);
        finish_frame(1'b0);
        check_output("final_pending", exp_addr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adc_frame_capture.md
ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 12, ADC sample width.
- C_NUM_ROWS, 160, rows per frame.
- C_SAMPLES_PER_ROW, 138, samples per row (46 mux slots x 3 ADC_CLK).
- ADDR_W, 15, write address width.
- C_DRAIN, 32, idle ADC_CLK cycles required before frame close (at least the conversion latency).
- C_ACK_LEN, 3, FSMIND0ACK high time in ADC_CLK cycles (one pixel clock).

REQ-002 Ports SHALL be:
- ADC_CLK, input, 1, capture clock.
- RESET, input, 1, synchronous active-high reset.
- ARM, input, 1, request capture of one frame.
- ADC_DATA, input, DATA_W, converted sample.
- ADC_DATA_VALID, input, 1, sample valid.
- FSMIND0, input, 1, readout FSM idle/done indicator.
- FSMIND0ACK, output, 1, acknowledge of FSMIND0.
- FSMIND1, output, 1, capture FSM requests readout.
- FSMIND1ACK, input, 1, readout FSM accepted request.
- WR_EN, output, 1, buffer write strobe.
- WR_ADDR, output, ADDR_W, buffer address.
- WR_DATA, output, DATA_W, buffer data.
- ROW_IDX, output, 8, current row.
- FRAME_DONE, output, 1, one-cycle frame-complete pulse.
- BUSY, output, 1, high in any state except IDLE.
- OVERFLOW, output, 1, sticky: sample dropped.
- SHORT_ROW, output, 1, sticky: row ended early.

REQ-003 Reset RESET SHALL be synchronous and active-high; the clock SHALL be ADC_CLK.

REQ-004 All inputs SHALL be sampled on posedge ADC_CLK without synchronisers; ADC_PIXCLK is a phase-related divide-by-3 of ADC_CLK.

Function
REQ-005 The FSM SHALL have states IDLE, REQ, CAPTURE, DRAIN, ACK, DONE.

REQ-006 Transitions SHALL be:
- IDLE -> REQ on ARM=1.
- REQ: FSMIND1=1. On FSMIND1ACK=1, deassert FSMIND1 and go to CAPTURE.
- CAPTURE -> DRAIN on FSMIND0=1.
- DRAIN -> ACK after C_DRAIN consecutive cycles with ADC_DATA_VALID=0.
- ACK: FSMIND0ACK=1 for C_ACK_LEN cycles, then go to DONE.
- DONE: FRAME_DONE=1 for one cycle, then go to IDLE.

REQ-007 In CAPTURE and DRAIN, each cycle with ADC_DATA_VALID=1 and sample count < C_SAMPLES_PER_ROW and row < C_NUM_ROWS SHALL write the sample in the same cycle with registered outputs. The write SHALL appear one cycle after the sample with WR_EN=1, WR_DATA=ADC_DATA, and WR_ADDR=row*C_SAMPLES_PER_ROW+sample.

REQ-008 A falling edge of ADC_DATA_VALID SHALL close the row: increment the row, clear the sample count, and set SHORT_ROW if the count was less than C_SAMPLES_PER_ROW.

REQ-009 A valid sample received when the count equals C_SAMPLES_PER_ROW, or when the row equals C_NUM_ROWS, SHALL be dropped (WR_EN=0) and SHALL set OVERFLOW.

REQ-010 ADC_DATA_VALID=1 in IDLE, REQ, ACK or DONE SHALL be ignored and SHALL NOT set any flag.

REQ-011 ADC_DATA_VALID=1 during DRAIN SHALL restart the C_DRAIN counter.

REQ-012 FSMIND0=1 while in REQ SHALL NOT advance the FSM.

REQ-013 Row and sample counters SHALL clear on entry to REQ. OVERFLOW and SHORT_ROW SHALL clear only on entry to REQ or on reset.

REQ-014 ROW_IDX SHALL equal the current row count and SHALL saturate at C_NUM_ROWS.

REQ-015 WR_ADDR arithmetic SHALL be performed at ADDR_W bits; the maximum address SHALL be C_NUM_ROWS*C_SAMPLES_PER_ROW-1 (22079 with default parameters).

REQ-016 ARM held high SHALL start a new frame immediately after DONE.

Reset
REQ-017 On RESET the state SHALL be IDLE and all outputs SHALL be 0, including FSMIND1, FSMIND0ACK, WR_EN, WR_ADDR, WR_DATA, ROW_IDX, FRAME_DONE, BUSY, OVERFLOW and SHORT_ROW.

REQ-018 RESET mid-frame SHALL abort with no further writes, and FSMIND1 SHALL drop in the next cycle.

Configuration
REQ-019 The macro ADC_FRAME_CAPTURE_TESTPAT_EN SHALL control the write data source:
- When defined, WR_DATA SHALL be WR_ADDR[DATA_W-1:0] in place of ADC_DATA; all timing and flags are unchanged.
- When undefined, WR_DATA SHALL be ADC_DATA.

Verification
REQ-020 Nominal frame: ARM pulse, FSMIND1ACK returned 6 cycles later, then 160 bursts of 138 valid cycles, then FSMIND0=1 -> exactly 22080 writes at addresses 0..22079, FSMIND0ACK high for 3 cycles, one FRAME_DONE pulse, both flags 0.

REQ-021 Row 5 burst of 140 valid cycles -> 138 writes for row 5 (addresses 690..827), OVERFLOW=1, row 6 starts at address 828.

REQ-022 Row 0 burst of 100 valid cycles -> SHORT_ROW=1, row 1 first write at address 138.

REQ-023 FSMIND0=1 raised while the last burst still has 24 valid cycles remaining -> all 24 samples written, and FSMIND0ACK asserts 32 cycles after valid falls.

REQ-024 RESET asserted during row 80 -> the next cycle shows WR_EN=0, FSMIND1=0, BUSY=0, ROW_IDX=0; a following ARM restarts at address 0.

REQ-025 With ADC_FRAME_CAPTURE_TESTPAT_EN defined, the nominal frame -> WR_DATA equals WR_ADDR modulo 4096 on every write.
